table_writer: RTL and testbench

TABLE_WRITER -- requirements
Module: table_writer

---
 rtl/table_writer_pkg.sv | 18 +
 rtl/table_writer_if.sv | 43 ++++
 rtl/table_writer_clr_cnt.sv | 28 ++
 rtl/table_writer.sv | 145 ++++++++++++++
 tb/tb_table_writer.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/table_writer_pkg.sv
// Shared constants, FSM state encoding and entry-kind encodings for table_writer.
package table_writer_pkg;

  localparam int unsigned TW_STATE_W = 8;
  localparam int unsigned TW_CHARA_W = 4;
  localparam int unsigned TW_ADDR_W  = TW_STATE_W + TW_CHARA_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_LOAD   = 2'd2,
    ST_FINISH = 2'd3
  } tw_state_e;

  localparam logic KIND_GOTO = 1'b0;
  localparam logic KIND_FAIL = 1'b1;

endpackage

// File: rtl/table_writer_if.sv
// Entry-stream, table write ports and status bundle for table_writer.
interface table_writer_if
  import table_writer_pkg::*;
#(
  parameter int unsigned STATE_W = TW_STATE_W,
  parameter int unsigned CHARA_W = TW_CHARA_W,
  parameter int unsigned ADDR_W  = TW_ADDR_W
) ();

  logic               start;
  logic               in_valid;
  logic               in_ready;
  logic               in_kind;
  logic [STATE_W-1:0] in_state;
  logic [CHARA_W-1:0] in_chara;
  logic [STATE_W-1:0] in_data;
  logic               in_last;

  logic               g_we;
  logic [ADDR_W-1:0]  g_addr;
  logic [STATE_W-1:0] g_wdata;
  logic               f_we;
  logic [ADDR_W-1:0]  f_addr;
  logic [STATE_W-1:0] f_wdata;

  logic               busy;
  logic               done;
  logic               err;
  logic [ADDR_W:0]    entry_cnt;

  modport master (
    output start, in_valid, in_kind, in_state, in_chara, in_data, in_last,
    input  in_ready, g_we, g_addr, g_wdata, f_we, f_addr, f_wdata,
    input  busy, done, err, entry_cnt
  );

  modport slave (
    input  start, in_valid, in_kind, in_state, in_chara, in_data, in_last,
    output in_ready, g_we, g_addr, g_wdata, f_we, f_addr, f_wdata,
    output busy, done, err, entry_cnt
  );

endinterface

// File: rtl/table_writer_clr_cnt.sv
// Clear-sweep address counter with terminal flag; present only when
// TABLE_WRITER_CLEAR_EN is defined.
`ifdef TABLE_WRITER_CLEAR_EN
module table_writer_clr_cnt #(
  parameter int unsigned W = 12
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_term_c
);

  // Counts while enabled, parks at zero otherwise so each sweep starts at 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cnt <= '0;
    end else if (i_en) begin
      o_cnt <= o_cnt + W'(1);
    end else begin
      o_cnt <= '0;
    end
  end

  assign o_term_c = &o_cnt;

endmodule
`endif

// File: rtl/table_writer.sv
// Builds goto/failure tables from an entry stream into two RAM write ports.
// TABLE_WRITER_CLEAR_EN: pre-zero both tables before loading.
module table_writer
  import table_writer_pkg::*;
#(
  parameter int unsigned STATE_W = TW_STATE_W,
  parameter int unsigned CHARA_W = TW_CHARA_W,
  parameter int unsigned ADDR_W  = TW_ADDR_W
) (
  input logic           i_clk,
  input logic           i_rst_n,
  table_writer_if.slave bus
);

  tw_state_e          r_state;
  logic               r_in_ready;
  logic               r_g_we;
  logic [ADDR_W-1:0]  r_g_addr;
  logic [STATE_W-1:0] r_g_wdata;
  logic               r_f_we;
  logic [ADDR_W-1:0]  r_f_addr;
  logic [STATE_W-1:0] r_f_wdata;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [ADDR_W:0]    r_entry_cnt;

  logic               w_accept;
  logic               w_fail_bad;
  logic [CHARA_W-1:0] w_chara;

  assign w_accept = r_in_ready & bus.in_valid;
  assign w_chara  = bus.in_chara;

  // A failure link must point strictly lower; the root may only fail to itself.
  assign w_fail_bad = (bus.in_state != '0) ? (bus.in_data >= bus.in_state)
                                           : (bus.in_data != '0);

`ifdef TABLE_WRITER_CLEAR_EN
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_clr_term;

  table_writer_clr_cnt #(.W(ADDR_W)) u_clr_cnt (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_en     (r_state == ST_CLEAR),
    .o_cnt    (w_clr_addr),
    .o_term_c (w_clr_term)
  );
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_g_we      <= 1'b0;
      r_g_addr    <= '0;
      r_g_wdata   <= '0;
      r_f_we      <= 1'b0;
      r_f_addr    <= '0;
      r_f_wdata   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_entry_cnt <= '0;
    end else begin
      r_g_we <= 1'b0;
      r_f_we <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_busy <= 1'b0;
          if (bus.start) begin
            r_busy      <= 1'b1;
            r_err       <= 1'b0;
            r_entry_cnt <= '0;
`ifdef TABLE_WRITER_CLEAR_EN
            r_state     <= ST_CLEAR;
`else
            r_state     <= ST_LOAD;
            r_in_ready  <= 1'b1;
`endif
          end
        end
`ifdef TABLE_WRITER_CLEAR_EN
        ST_CLEAR: begin
          r_g_we    <= 1'b1;
          r_g_addr  <= w_clr_addr;
          r_g_wdata <= '0;
          r_f_we    <= (w_clr_addr[ADDR_W-1:STATE_W] == '0);
          r_f_addr  <= ADDR_W'(w_clr_addr[STATE_W-1:0]);
          r_f_wdata <= '0;
          if (w_clr_term) begin
            r_state    <= ST_LOAD;
            r_in_ready <= 1'b1;
          end
        end
`endif
        ST_LOAD: begin
          if (w_accept) begin
            if (!(&r_entry_cnt)) begin
              r_entry_cnt <= r_entry_cnt + (ADDR_W+1)'(1);
            end
            if (bus.in_kind == KIND_GOTO) begin
              r_g_we    <= 1'b1;
              r_g_addr  <= ADDR_W'({bus.in_state, w_chara});
              r_g_wdata <= bus.in_data;
            end else if (w_fail_bad) begin
              r_err <= 1'b1;
            end else begin
              r_f_we    <= 1'b1;
              r_f_addr  <= ADDR_W'(bus.in_state);
              r_f_wdata <= bus.in_data;
            end
            if (bus.in_last) begin
              r_state    <= ST_FINISH;
              r_in_ready <= 1'b0;
            end
          end
        end
        ST_FINISH: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.g_we      = r_g_we;
  assign bus.g_addr    = r_g_addr;
  assign bus.g_wdata   = r_g_wdata;
  assign bus.f_we      = r_f_we;
  assign bus.f_addr    = r_f_addr;
  assign bus.f_wdata   = r_f_wdata;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.entry_cnt = r_entry_cnt;

endmodule

// File: tb/tb_table_writer.sv
// Scoreboard bench for table_writer: expected writes queued at issue time,
// checked by a negedge monitor on the goto and failure write ports.
module tb_table_writer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  table_writer_if bus ();

  table_writer u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  logic [19:0] gq[$];
  logic [19:0] fq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Write-port monitor: every write must match the oldest expected one.
  always @(negedge clk) begin
    logic [19:0] e;
    if (bus.g_we) begin
      if (gq.size() == 0) chk("g_unexpected_we", 32'(bus.g_we), 32'd0);
      else begin
        e = gq.pop_front();
        chk("g_write", 32'({bus.g_addr, bus.g_wdata}), 32'(e));
      end
    end
    if (bus.f_we) begin
      if (fq.size() == 0) chk("f_unexpected_we", 32'(bus.f_we), 32'd0);
      else begin
        e = fq.pop_front();
        chk("f_write", 32'({bus.f_addr, bus.f_wdata}), 32'(e));
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 0);
    chk({tag, "_g_we"},     32'(bus.g_we), 0);
    chk({tag, "_f_we"},     32'(bus.f_we), 0);
    chk({tag, "_g_addr"},   32'(bus.g_addr), 0);
    chk({tag, "_f_addr"},   32'(bus.f_addr), 0);
    chk({tag, "_g_wdata"},  32'(bus.g_wdata), 0);
    chk({tag, "_f_wdata"},  32'(bus.f_wdata), 0);
    chk({tag, "_busy"},     32'(bus.busy), 0);
    chk({tag, "_done"},     32'(bus.done), 0);
    chk({tag, "_err"},      32'(bus.err), 0);
    chk({tag, "_cnt"},      32'(bus.entry_cnt), 0);
  endtask

  task automatic do_start();
    logic rdy;
`ifdef TABLE_WRITER_CLEAR_EN
    for (int a = 0; a < 4096; a++) gq.push_back({12'(a), 8'h00});
    for (int a = 0; a < 256; a++)  fq.push_back({12'(a), 8'h00});
`endif
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("start_busy", 32'(bus.busy), 1);
    rdy = bus.in_ready;
    for (int n = 0; n < 5000 && !rdy; n++) begin
      @(posedge clk); #1;
      rdy = bus.in_ready;
    end
    chk("start_ready", 32'(rdy), 1);
  endtask

  // Issue one beat; the expected write (if any) is queued at the accepting edge.
  task automatic beat(input logic kind, input logic [7:0] st, input logic [3:0] ch,
                      input logic [7:0] dt, input logic last, input logic exp_wr);
    logic acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_kind  = kind;
    bus.in_state = st;
    bus.in_chara = ch;
    bus.in_data  = dt;
    bus.in_last  = last;
    for (int n = 0; n < 50 && !acc; n++) begin
      acc = bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("beat_accepted", 32'(acc), 1);
    if (acc && exp_wr) begin
      if (kind) fq.push_back({12'(st), dt});
      else      gq.push_back({st, ch, dt});
    end
  endtask

  initial begin
    logic [19:0] pat;
    logic        rdy;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_kind  = 1'b0;
    bus.in_state = '0;
    bus.in_chara = '0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    pat = 20'b1011_0011_1110_0101_0111;

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // First build: directed goto/failure entries including error boundaries.
    do_start();
    beat(1'b0, 8'd3, 4'd5, 8'd7, 1'b0, 1'b1);
    beat(1'b1, 8'd4, 4'd0, 8'd6, 1'b0, 1'b0);
    chk("err_set", 32'(bus.err), 1);
    chk("cnt_after_err", 32'(bus.entry_cnt), 2);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("start_ignored_cnt", 32'(bus.entry_cnt), 2);
    chk("start_ignored_err", 32'(bus.err), 1);
    beat(1'b1, 8'd0, 4'd0, 8'd0, 1'b0, 1'b1);
    beat(1'b1, 8'd0, 4'd0, 8'd3, 1'b0, 1'b0);
    beat(1'b1, 8'd5, 4'd0, 8'd5, 1'b0, 1'b0);
    beat(1'b1, 8'd5, 4'd0, 8'd4, 1'b0, 1'b1);
    beat(1'b1, 8'd9, 4'd0, 8'd2, 1'b1, 1'b1);
    chk("finish_ready_low", 32'(bus.in_ready), 0);
    @(posedge clk); #1;
    chk("done_pulse", 32'(bus.done), 1);
    chk("busy_during_done", 32'(bus.busy), 1);
    @(posedge clk); #1;
    chk("done_cleared", 32'(bus.done), 0);
    chk("busy_cleared", 32'(bus.busy), 0);
    chk("cnt_final", 32'(bus.entry_cnt), 7);

    // Valid beats while idle must be ignored.
    bus.in_valid = 1'b1;
    bus.in_kind  = 1'b0;
    bus.in_state = 8'h44;
    bus.in_data  = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("idle_cnt_hold", 32'(bus.entry_cnt), 7);
    chk("idle_err_hold", 32'(bus.err), 1);

    // Second build: toggling valid, then reset mid-load.
    do_start();
    chk("restart_err", 32'(bus.err), 0);
    chk("restart_cnt", 32'(bus.entry_cnt), 0);
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = pat[i];
      bus.in_kind  = 1'b0;
      bus.in_state = 8'(i + 16);
      bus.in_chara = 4'(i) ^ 4'hA;
      bus.in_data  = 8'(i + 1);
      rdy = bus.in_ready;
      @(posedge clk); #1;
      if (rdy && pat[i]) gq.push_back({8'(i + 16), 4'(i) ^ 4'hA, 8'(i + 1)});
    end
    bus.in_valid = 1'b0;
    chk("toggle_cnt", 32'(bus.entry_cnt), 13);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midload_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_idle_ready", 32'(bus.in_ready), 0);

    // Third build after reset.
    do_start();
    chk("reset_restart_cnt", 32'(bus.entry_cnt), 0);
    beat(1'b0, 8'h01, 4'h2, 8'h03, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("done_third", 32'(bus.done), 1);
    chk("cnt_third", 32'(bus.entry_cnt), 1);
    repeat (2) @(posedge clk);
    #1;
    chk("g_queue_drained", 32'(gq.size()), 0);
    chk("f_queue_drained", 32'(fq.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
